// File: rtl/ring_phase_tracker_pkg.sv
// ring_pkg: shared state encoding and default sizing for ring_phase_tracker.
package ring_pkg;
  typedef enum logic [1:0] {SEARCH, LOCKED, FAULT} state_e;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_REV_W = 8;
endpackage

// File: rtl/ring_phase_tracker_if.sv
// ring_phase_tracker_if: ring sample/clear inputs and tracker status outputs.
interface ring_phase_tracker_if #(
  parameter int WIDTH = ring_pkg::DEF_WIDTH,
  parameter int REV_W = ring_pkg::DEF_REV_W
);
  logic [WIDTH-1:0]         ring_in;
  logic                     clear_err;
  logic [$clog2(WIDTH)-1:0] phase;
  logic                     phase_valid;
  logic [REV_W-1:0]         rev_count;
  logic                     rev_pulse;
  logic                     err_onehot;
  logic                     err_order;
  modport master (output ring_in, clear_err,
                  input phase, phase_valid, rev_count, rev_pulse, err_onehot, err_order);
  modport slave  (input ring_in, clear_err,
                  output phase, phase_valid, rev_count, rev_pulse, err_onehot, err_order);
endinterface

// File: rtl/ring_phase_tracker_onehot_enc.sv
// onehot_enc: binary index of a set bit plus an exactly-one-bit-set flag.
module onehot_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     onehot_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++)
      if (vec_i[i]) idx_o = idx_o | ($clog2(WIDTH))'(i);
  end
  assign onehot_o = $onehot(vec_i);
endmodule

// File: rtl/ring_phase_tracker.sv
// ring_phase_tracker: locks onto a rotating one-hot ring and flags illegal samples.
// Define RING_TRACK_REV_EN to build the revolution counter and rev_pulse.
module ring_phase_tracker
  import ring_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REV_W = DEF_REV_W
) (
  input logic                 clk,
  input logic                 reset,
  ring_phase_tracker_if.slave bus
);
  localparam int PW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, idx, nxt;
  logic oh, stall, adv, eoh_q, eoh_d, eord_q, eord_d;
  onehot_enc #(.WIDTH(WIDTH)) u_enc (.vec_i(bus.ring_in), .idx_o(idx), .onehot_o(oh));
  // Rotation legality is judged on the locked index rather than the raw bits.
  assign nxt   = phase_q == PW'(WIDTH - 1) ? '0 : phase_q + 1'b1;
  assign stall = idx == phase_q;
  assign adv   = idx == nxt;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    eoh_d   = eoh_q & ~bus.clear_err;
    eord_d  = eord_q & ~bus.clear_err;
    unique case (state_q)
      SEARCH: if (oh) begin
        state_d = LOCKED;
        phase_d = idx;
      end
      LOCKED: if (!oh) begin
        state_d = FAULT;
        eoh_d   = 1'b1;
      end else if (stall || adv) phase_d = idx;
      else begin
        state_d = FAULT;
        eord_d  = 1'b1;
      end
      FAULT:   if (bus.clear_err) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= SEARCH;
      phase_q <= '0;
      eoh_q   <= 1'b0;
      eord_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      eoh_q   <= eoh_d;
      eord_q  <= eord_d;
    end
  assign bus.phase       = phase_q;
  assign bus.phase_valid = state_q == LOCKED;
  assign bus.err_onehot  = eoh_q;
  assign bus.err_order   = eord_q;
`ifdef RING_TRACK_REV_EN
  logic [REV_W-1:0] rev_q;
  logic pulse_q, wrap;
  assign wrap = state_q == LOCKED && oh && adv && phase_q == PW'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rev_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      rev_q   <= rev_q + REV_W'(wrap);
      pulse_q <= wrap;
    end
  assign bus.rev_count = rev_q;
  assign bus.rev_pulse = pulse_q;
`else
  assign bus.rev_count = {REV_W{1'b0}};
  assign bus.rev_pulse = 1'b0;
`endif
endmodule
